// File: rtl/seg_scan_drv.sv
// Multiplexed scan driver for a 6-digit common-anode seven-segment display with anti-ghost blanking
// and frame-aligned (tear-free) value updates. Optional leading-zero suppression: SEG_LZ_BLANK_EN.
module seg_scan_drv #(
  parameter int SCAN_CNT  = 50_000,
  parameter int BLANK_CNT = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] din,
  input  logic [5:0]  dp,
  input  logic        din_vld,
  output logic [7:0]  dig,
  output logic [5:0]  sel,
  output logic        frame_done
);

  localparam int CW = $clog2(SCAN_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_CNT - 1);

  typedef enum logic {BLANK, ON} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic          slot_end, boundary;
  logic [23:0]   disp_val, pend_val;
  logic [5:0]    disp_dp, pend_dp;
  logic          pend_flag;
  logic [3:0]    nib;
  logic [5:0]    lz;
  logic [7:0]    seg;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;  4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;  4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;  4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;  4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    slot_end  = (cnt == CNT_MAX);
    boundary  = slot_end && (idx == 3'd5);
    cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
    idx_nxt   = idx;
    if (slot_end) idx_nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    state_nxt = (32'(cnt_nxt) < BLANK_CNT) ? BLANK : ON;
  end

  assign frame_done = boundary;

  always_comb begin : decode
    logic run;
    run = 1'b1;
    lz  = '0;
    nib = disp_val[{idx, 2'b00} +: 4];
`ifdef SEG_LZ_BLANK_EN
    // Walk down from the most significant digit; digit 0 is never suppressed.
    for (int k = 5; k >= 1; k--) begin
      run   = run && (disp_val[4*k +: 4] == 4'd0) && !disp_dp[k];
      lz[k] = run;
    end
`endif
    seg = seg7(nib) & ~{disp_dp[idx], 7'b0};
    if (lz[idx]) seg = 8'hFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig <= 8'hFF;
      sel <= 6'h3F;
    end else if (state == ON) begin
      dig <= seg;
      sel <= 6'h3F ^ (6'd1 << idx);
    end else begin
      dig <= 8'hFF;
      sel <= 6'h3F;
    end
  end

  // A strobe landing on the boundary itself bypasses the pending register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_val  <= '0;
      disp_dp   <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
    end else if (boundary) begin
      pend_flag <= 1'b0;
      if (din_vld) begin
        disp_val <= din;
        disp_dp  <= dp;
      end else if (pend_flag) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
    end else if (din_vld) begin
      pend_val  <= din;
      pend_dp   <= dp;
      pend_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Scoreboard bench for seg_scan_drv with SCAN_CNT=10, BLANK_CNT=2.
module tb_seg_scan_drv;

  localparam int SC = 10;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] din = '0;
  logic [5:0]  dp = '0;
  logic        din_vld = 1'b0;
  logic [7:0]  dig;
  logic [5:0]  sel;
  logic        frame_done;

  seg_scan_drv #(.SCAN_CNT(SC), .BLANK_CNT(BC)) dut (
    .clk(clk), .rst(rst), .din(din), .dp(dp), .din_vld(din_vld),
    .dig(dig), .sel(sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] sel; logic [7:0] dig; } exp_t;
  typedef struct { int pos; logic [23:0] v; logic [5:0] d; } stb_t;

  exp_t sb[$];
  stb_t stq[$];
  int   pos;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] seg_ref(input logic [3:0] n);
    logic [7:0] t [16];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[n];
  endfunction

  // Expected slot contents for one full frame (digit 0 first).
  task automatic push_frame(input logic [23:0] v, input logic [5:0] d);
    exp_t e;
    logic [5:0] blank_mask;
    logic lead;
    blank_mask = '0;
    lead = 1'b1;
`ifdef SEG_LZ_BLANK_EN
    for (int k = 5; k >= 1; k--) begin
      if (v[4*k +: 4] != 4'd0 || d[k]) lead = 1'b0;
      blank_mask[k] = lead;
    end
`endif
    for (int k = 0; k < 6; k++) begin
      e.sel = 6'h3F ^ (6'd1 << k);
      e.dig = blank_mask[k] ? 8'hFF : (seg_ref(v[4*k +: 4]) & (d[k] ? 8'h7F : 8'hFF));
      sb.push_back(e);
    end
  endtask

  task automatic step();
    stb_t s;
    @(negedge clk);
    pos++;
    din_vld = 1'b0;
    if (stq.size() > 0 && stq[0].pos == pos) begin
      s = stq.pop_front();
      din = s.v;
      dp = s.d;
      din_vld = 1'b1;
    end
  endtask

  // Entered at the negedge where cnt=0, idx=0; leaves at the next such negedge.
  task automatic check_frame();
    exp_t e;
    pos = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("blank_sel", sel, 6'h3F);
      check("blank_dig", dig, 8'hFF);
      step();
      step();
      if (sb.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        check("on_sel", sel, e.sel);
        check("on_dig", dig, e.dig);
        repeat (6) step();
        check("on_sel_end", sel, e.sel);
        check("on_dig_end", dig, e.dig);
      end
      check("frame_done", frame_done, (k == 5));
      step();
    end
  endtask

  initial begin
    stb_t s;
    repeat (3) @(negedge clk);
    check("rst_dig", dig, 8'hFF);
    check("rst_sel", sel, 6'h3F);
    check("rst_fd", frame_done, 0);
    rst = 1'b0;

    // Frame 0: reset contents; queue 12_3456 for frame 1.
    push_frame(24'h0, 6'h0);
    s = '{pos: 20, v: 24'h123456, d: 6'h0}; stq.push_back(s);
    check_frame();

    // Frame 1: 12_3456; two strobes, the later wins.
    push_frame(24'h123456, 6'h0);
    s = '{pos: 10, v: 24'hAAAAAA, d: 6'h0}; stq.push_back(s);
    s = '{pos: 40, v: 24'h00000F, d: 6'h0}; stq.push_back(s);
    check_frame();

    // Frame 2: 00000F; strobe on the boundary cycle commits directly.
    push_frame(24'h00000F, 6'h0);
    s = '{pos: 59, v: 24'h000008, d: 6'h0}; stq.push_back(s);
    check_frame();

    // Frame 3: 000008; queue zero value with digit-0 decimal point.
    push_frame(24'h000008, 6'h0);
    s = '{pos: 30, v: 24'h0, d: 6'b000001}; stq.push_back(s);
    check_frame();

    // Frame 4: dp test, then reset in digit 3's ON slot with an update pending.
    push_frame(24'h0, 6'b000001);
    s = '{pos: 5, v: 24'hABCDEF, d: 6'h0}; stq.push_back(s);
    pos = 0;
    for (int k = 0; k < 3; k++) begin
      repeat (3) step();
      if (sb.size() > 0) begin
        s.pos = 0;
        check("dp_dig", dig, sb[0].dig);
        check("dp_sel", sel, sb[0].sel);
        void'(sb.pop_front());
      end
      repeat (7) step();
    end
    while (pos < 35) step();
    check("pre_rst_sel", sel, 6'h37);
    rst = 1'b1;
    #1;
    check("mid_rst_dig", dig, 8'hFF);
    check("mid_rst_sel", sel, 6'h3F);
    check("mid_rst_fd", frame_done, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Scanning restarts at digit 0 with zero; the pending value never appears.
    push_frame(24'h0, 6'h0);
    push_frame(24'h0, 6'h0);
    check_frame();
    check_frame();
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
